// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with a per-register busy scoreboard.
//
// Purpose:
//   Holds REG_NUM architectural registers of REG_LEN bits. Register 0 is
//   hardwired to zero. Two combinational read ports return operand data and
//   a busy flag that says whether an older instruction still owes a result
//   to that register. Issue marks a destination pending. Write-back stores
//   data and clears the pending mark. Flush clears every pending mark.
//   With BYPASS=1, a write-back is forwarded to the read ports in the same
//   cycle, and the busy flag is masked for that read.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rs1, rs2            read addresses
//   rs1_d, rs2_d        read data (combinational)
//   rs1_busy, rs2_busy  operand has an outstanding producer (combinational)
//   rd, rd_d, reg_wr    write-back address, data and enable
//   iss_rd, iss_vld     destination of the issuing instruction, issue enable
//   flush               clear all busy bits
//   pend_cnt            registered count of busy registers
module reg_file_sb #(
  parameter int REG_LEN  = 32,
  parameter int ADDR_LEN = 5,
  parameter int REG_NUM  = 32,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_LEN-1:0] rs1,
  input  logic [ADDR_LEN-1:0] rs2,
  output logic [REG_LEN-1:0]  rs1_d,
  output logic [REG_LEN-1:0]  rs2_d,
  output logic                rs1_busy,
  output logic                rs2_busy,
  input  logic [ADDR_LEN-1:0] rd,
  input  logic [REG_LEN-1:0]  rd_d,
  input  logic                reg_wr,
  input  logic [ADDR_LEN-1:0] iss_rd,
  input  logic                iss_vld,
  input  logic                flush,
  output logic [ADDR_LEN:0]   pend_cnt
);

  // Storage starts at index 1. Register 0 has no flop and always reads
  // as zero.
  logic [REG_LEN-1:0] regs_q [1:REG_NUM-1];
  logic [REG_LEN-1:0] regs_d [1:REG_NUM-1];
  logic [REG_NUM-1:1] busy_q;
  logic [REG_NUM-1:1] busy_d;
  logic [ADDR_LEN:0]  pend_cnt_q;
  logic [ADDR_LEN:0]  pend_cnt_d;

  // Set when the write-back targets a real, writable register. Address 0
  // and out-of-range addresses never match the loop index.
  logic wr_hit;

  always_comb begin : wr_decode
    wr_hit = 1'b0;
    for (int i = 1; i < REG_NUM; i++) begin
      if (reg_wr && rd == ADDR_LEN'(i)) begin
        wr_hit = 1'b1;
      end
    end
  end

  // Next state. The assignments are ordered so that the later ones take
  // priority: write-back clears, issue sets, and flush clears all.
  always_comb begin : next_state
    regs_d     = regs_q;
    busy_d     = busy_q;
    pend_cnt_d = '0;
    for (int i = 1; i < REG_NUM; i++) begin
      if (reg_wr && rd == ADDR_LEN'(i)) begin
        regs_d[i] = rd_d;
        busy_d[i] = 1'b0;
      end
      if (iss_vld && iss_rd == ADDR_LEN'(i)) begin
        busy_d[i] = 1'b1;
      end
      if (flush) begin
        busy_d[i] = 1'b0;
      end
      pend_cnt_d = pend_cnt_d + (ADDR_LEN+1)'(busy_d[i]);
    end
  end

  // Read ports. Address 0 and unmapped addresses fall through to zero and
  // not-busy. A same-cycle write-back overrides the stored value and
  // clears the busy flag when forwarding is enabled.
  always_comb begin : read_ports
    rs1_d    = '0;
    rs2_d    = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    for (int i = 1; i < REG_NUM; i++) begin
      if (rs1 == ADDR_LEN'(i)) begin
        rs1_d    = regs_q[i];
        rs1_busy = busy_q[i];
      end
      if (rs2 == ADDR_LEN'(i)) begin
        rs2_d    = regs_q[i];
        rs2_busy = busy_q[i];
      end
    end
    if (BYPASS != 0) begin
      if (wr_hit && rd == rs1) begin
        rs1_d    = rd_d;
        rs1_busy = 1'b0;
      end
      if (wr_hit && rd == rs2) begin
        rs2_d    = rd_d;
        rs2_busy = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb. Two instances share the same stimulus: one with
// forwarding enabled and one without. Both are compared on every falling
// edge against an array-based reference model. Directed scenarios add
// literal expectations, and a randomized phase follows them.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, iss_rd = '0;
  logic [31:0] rd_d = '0;
  logic        reg_wr = 1'b0, iss_vld = 1'b0, flush = 1'b0;

  logic [31:0] b1_rs1_d, b1_rs2_d, b0_rs1_d, b0_rs2_d;
  logic        b1_rs1_busy, b1_rs2_busy, b0_rs1_busy, b0_rs2_busy;
  logic [5:0]  b1_pend, b0_pend;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.REG_LEN(32), .ADDR_LEN(5), .REG_NUM(32), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
    .rs1_d(b1_rs1_d), .rs2_d(b1_rs2_d),
    .rs1_busy(b1_rs1_busy), .rs2_busy(b1_rs2_busy),
    .rd(rd), .rd_d(rd_d), .reg_wr(reg_wr),
    .iss_rd(iss_rd), .iss_vld(iss_vld), .flush(flush),
    .pend_cnt(b1_pend));

  reg_file_sb #(.REG_LEN(32), .ADDR_LEN(5), .REG_NUM(32), .BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
    .rs1_d(b0_rs1_d), .rs2_d(b0_rs2_d),
    .rs1_busy(b0_rs1_busy), .rs2_busy(b0_rs2_busy),
    .rd(rd), .rd_d(rd_d), .reg_wr(reg_wr),
    .iss_rd(iss_rd), .iss_vld(iss_vld), .flush(flush),
    .pend_cnt(b0_pend));

  // Reference model: architectural contents plus a pending flag per register.
  logic [31:0] m_reg  [32];
  logic        m_busy [32];

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  end

  // The nonblocking writes are ordered so that the later ones win:
  // write-back clears, issue sets, and flush clears everything.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  <= '0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      if (reg_wr && rd != 0) begin
        m_reg[rd]  <= rd_d;
        m_busy[rd] <= 1'b0;
      end
      if (iss_vld && iss_rd != 0) m_busy[iss_rd] <= 1'b1;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] <= 1'b0;
      end
    end
  end

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && reg_wr && rd == a) return rd_d;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && reg_wr && rd == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [31:0] exp_pend();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return 32'(n);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("m_b1_rs1_d",    b1_rs1_d,           exp_data(rs1, 1'b1));
    chk("m_b1_rs2_d",    b1_rs2_d,           exp_data(rs2, 1'b1));
    chk("m_b1_rs1_busy", 32'(b1_rs1_busy),   32'(exp_busy(rs1, 1'b1)));
    chk("m_b1_rs2_busy", 32'(b1_rs2_busy),   32'(exp_busy(rs2, 1'b1)));
    chk("m_b1_pend",     32'(b1_pend),       exp_pend());
    chk("m_b0_rs1_d",    b0_rs1_d,           exp_data(rs1, 1'b0));
    chk("m_b0_rs2_d",    b0_rs2_d,           exp_data(rs2, 1'b0));
    chk("m_b0_rs1_busy", 32'(b0_rs1_busy),   32'(exp_busy(rs1, 1'b0)));
    chk("m_b0_rs2_busy", 32'(b0_rs2_busy),   32'(exp_busy(rs2, 1'b0)));
    chk("m_b0_pend",     32'(b0_pend),       exp_pend());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    reg_wr  = 1'b0;
    iss_vld = 1'b0;
    flush   = 1'b0;
    rd      = '0;
    iss_rd  = '0;
    rd_d    = '0;
  endtask

  initial begin
    // Reset state.
    #2;
    rs1 = 5'd5;
    rs2 = 5'd31;
    #1;
    chk("rst_rs1_d", b1_rs1_d, 32'h0);
    chk("rst_rs2_d", b0_rs2_d, 32'h0);
    chk("rst_busy",  32'(b1_rs1_busy | b0_rs2_busy), 32'h0);
    chk("rst_pend",  32'(b1_pend), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Register 0 ignores writes and issues.
    reg_wr = 1'b1; rd = 5'd0; rd_d = 32'hFFFF_FFFF;
    iss_vld = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
    at_neg();
    chk("x0_same_d", b1_rs1_d, 32'h0);
    step();
    idle();
    rs1 = 5'd0;
    at_neg();
    chk("x0_d",    b1_rs1_d, 32'h0);
    chk("x0_busy", 32'(b1_rs1_busy), 32'h0);
    chk("x0_pend", 32'(b1_pend), 32'h0);

    // Bypass behaviour.
    step();
    reg_wr = 1'b1; rd = 5'd7; rd_d = 32'h11;
    step();
    rd_d = 32'h22; rs1 = 5'd7; rs2 = 5'd7;
    at_neg();
    chk("byp_rs1_d",   b1_rs1_d, 32'h22);
    chk("byp_rs2_d",   b1_rs2_d, 32'h22);
    chk("byp_busy",    32'(b1_rs1_busy | b1_rs2_busy), 32'h0);
    chk("nobyp_rs1_d", b0_rs1_d, 32'h11);
    chk("nobyp_rs2_d", b0_rs2_d, 32'h11);
    step();
    idle();
    at_neg();
    chk("nobyp_next_d", b0_rs1_d, 32'h22);

    // Scoreboard set, then clear.
    step();
    iss_vld = 1'b1; iss_rd = 5'd3;
    step();
    idle();
    rs1 = 5'd3;
    at_neg();
    chk("sb_set_busy", 32'(b0_rs1_busy), 32'h1);
    chk("sb_set_pend", 32'(b0_pend), 32'h1);
    step();
    reg_wr = 1'b1; rd = 5'd3; rd_d = 32'h55;
    step();
    idle();
    at_neg();
    chk("sb_clr_busy", 32'(b0_rs1_busy), 32'h0);
    chk("sb_clr_pend", 32'(b0_pend), 32'h0);
    chk("sb_clr_d",    b0_rs1_d, 32'h55);

    // Simultaneous set and clear on the same index.
    step();
    iss_vld = 1'b1; iss_rd = 5'd9;
    step();
    reg_wr = 1'b1; rd = 5'd9; rd_d = 32'h99;
    step();
    idle();
    rs1 = 5'd9;
    at_neg();
    chk("sc_busy", 32'(b1_rs1_busy), 32'h1);
    chk("sc_d",    b1_rs1_d, 32'h99);
    chk("sc_pend", 32'(b1_pend), 32'h1);

    // Flush combined with an issue and a write-back.
    step();
    flush = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      step();
      idle();
      iss_vld = 1'b1;
      iss_rd  = 5'(r);
    end
    step();
    idle();
    at_neg();
    chk("fl_pend3", 32'(b1_pend), 32'h3);
    step();
    flush = 1'b1; iss_vld = 1'b1; iss_rd = 5'd4;
    reg_wr = 1'b1; rd = 5'd2; rd_d = 32'hA5;
    step();
    idle();
    rs1 = 5'd2; rs2 = 5'd4;
    at_neg();
    chk("fl_pend",  32'(b1_pend), 32'h0);
    chk("fl_busy",  32'(b1_rs1_busy | b1_rs2_busy | b0_rs1_busy | b0_rs2_busy), 32'h0);
    chk("fl_x2",    b0_rs1_d, 32'hA5);

    // Asynchronous reset in the middle of operation.
    step();
    reg_wr = 1'b1; rd = 5'd5; rd_d = 32'hDEAD_BEEF;
    iss_vld = 1'b1; iss_rd = 5'd5;
    step();
    idle();
    rs1 = 5'd5;
    at_neg();
    chk("ar_pre_d",    b0_rs1_d, 32'hDEAD_BEEF);
    chk("ar_pre_busy", 32'(b0_rs1_busy), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_d",    b1_rs1_d, 32'h0);
    chk("ar_busy", 32'(b1_rs1_busy | b0_rs1_busy), 32'h0);
    chk("ar_pend", 32'(b1_pend), 32'h0);
    #1 rst_n = 1'b1;

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      step();
      rs1     = 5'($urandom_range(0, 31));
      rs2     = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rd      = 5'($urandom_range(0, 31));
      rd_d    = $urandom;
      reg_wr  = ($urandom_range(0, 1) == 1);
      iss_rd  = ($urandom_range(0, 7) == 0) ? rd : 5'($urandom_range(0, 31));
      iss_vld = ($urandom_range(0, 9) < 6);
      flush   = ($urandom_range(0, 47) == 0);
      if ($urandom_range(0, 3) == 0) rs1 = rd;
      if (c == 1500) begin
        at_neg();
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    step();
    idle();
    at_neg();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
